ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched operands (read_data_1/2) and funct3 from ID/EX. Asserts stall to freeze IF/ID and ID/EX while busy, and delivers one result to the EX result mux.
- Radix-2: one bit per cycle, magnitude datapath with sign fix-up.

Parameters:
data_bits, 32, operand/result width; iteration counter width = $clog2(data_bits)+1

Ports:
clk  input  1  pipeline clock, rising edge
n_reset  input  1  asynchronous, active-low reset
start  input  1  ID/EX holds a valid M-extension op this cycle
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  data_bits  rs1 value (ID/EX read_data_1_out)
operand_b  input  data_bits  rs2 value (ID/EX read_data_2_out)
flush  input  1  synchronous abort (branch taken / pipeline clear)
stall  output  1  hold upstream pipeline registers
done  output  1  result valid, one-cycle pulse
result  output  data_bits  selected product half / quotient / remainder

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (n_reset).
- Reset values: state=IDLE, done=0, result=0, counter=0, all internal registers 0. Reset asserted mid-operation aborts immediately with no done.
- States: IDLE, CALC, FIX, DONE.
- Timing convention: cycle 0 = cycle in which start is sampled in IDLE.
- IDLE, start=1, normal op:
  - Latch magnitudes of operands; sign handling: MUL/MULH/DIV/REM signed both, MULHSU a signed / b unsigned, MULHU/DIVU/REMU unsigned.
  - Latch result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Latch funct3, counter=0, go to CALC.
- CALC, one iteration per cycle, exactly data_bits cycles (cycles 1..32), then FIX:
  - Multiply: shift-add into a 2*data_bits accumulator.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
- FIX (cycle 33): two's-complement negate per latched sign, select output, register into result; go to DONE.
  - MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE (cycle 34): done=1, then IDLE unconditionally.
- Fast paths, decided in IDLE (IDLE -> DONE, done at cycle 1, no CALC):
  - Divisor zero: DIV/DIVU result = all ones; REM/REMU result = operand_a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result = 0x80000000, REM result = 0.
- Stall: combinational, stall = (state==IDLE & start) | state==CALC | state==FIX. Low in DONE, so the upstream stage advances on the done edge.
- result holds its value until the next FIX or fast path writes it. done is never high outside DONE.
- start while not IDLE: ignored, never queued.
- start in DONE: ignored. Upstream only re-presents an op after stall falls.
- flush (sync, highest priority after reset):
  - Any state -> IDLE next edge; done forced 0 that cycle; result unchanged.
  - flush & start in IDLE: start ignored; stall still follows the formula in that cycle.
- Counter wraps at no point; the CALC exit compare is counter==data_bits-1.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> stall high cycles 0..33; done at cycle 34; result 0xFFFFFFEB.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. Same operands with MULH -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> done cycle 1, result 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done cycle 1.
- DIV started, flush at cycle 10 -> state IDLE at cycle 11, stall 0, no done pulse, result keeps previous value. A new start at cycle 12 completes normally at cycle 46.
- n_reset low at cycle 5 of MUL (asynchronous, mid-cycle) -> stall, done and result 0 immediately. After release, start is accepted. Back-to-back ops (second start in the cycle after done) each produce one done pulse.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes one bit per cycle, then applies the sign fix-up.
module ex_muldiv_unit #(
  parameter int data_bits = 32
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [data_bits-1:0] operand_a,
  input  logic [data_bits-1:0] operand_b,
  input  logic                 flush,
  output logic                 stall,
  output logic                 done,
  output logic [data_bits-1:0] result
);
  localparam int W  = data_bits;
  localparam int CW = $clog2(data_bits) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_mag_q, a_mag_d;
  logic [W-1:0]    b_mag_q, b_mag_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    result_q, result_d;

  // Operand decode for the op presented in IDLE
  logic         is_div, a_signed, b_signed, sa, sb, op_neg;
  logic         div_zero, div_ovf, fast_path;
  logic [W-1:0] a_mag, b_mag, fast_result;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = is_div ? ~funct3[0] : ~funct3[1];
    sa       = a_signed & operand_a[W-1];
    sb       = b_signed & operand_b[W-1];
    a_mag    = sa ? (~operand_a + W'(1)) : operand_a;
    b_mag    = sb ? (~operand_b + W'(1)) : operand_b;
    // Remainder takes the dividend's sign; products and quotients take sa^sb.
    op_neg   = (is_div & funct3[1]) ? sa : (sa ^ sb);
    div_zero = is_div & (operand_b == '0);
    div_ovf  = is_div & ~funct3[0] & (operand_a == {1'b1, {(W-1){1'b0}}}) & (&operand_b);
    fast_path = div_zero | div_ovf;
    if (div_zero) fast_result = funct3[1] ? operand_a : '1;
    else          fast_result = funct3[1] ? '0 : operand_a;
  end

  // One iteration of each algorithm on the shared accumulator
  logic [W:0]     mul_sum;
  logic [2*W:0]   div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, a_mag_q} & {(W+1){acc_q[0]}});
    mul_step  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q, 1'b0};
    div_diff  = div_shift[2*W:W] - {1'b0, b_mag_q};
    div_step  = div_diff[W] ? div_shift[2*W-1:0]
                            : {div_diff[W-1:0], div_shift[W-1:1], 1'b1};
  end

  // Final sign fix-up and half/quotient/remainder selection
  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo, rem, fix_result;

  always_comb begin
    prod_signed = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
    quo         = neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    rem         = neg_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
    unique case (funct3_q[2:1])
      2'b00:   fix_result = (funct3_q[0]) ? prod_signed[2*W-1:W] : prod_signed[W-1:0];
      2'b01:   fix_result = prod_signed[2*W-1:W];
      2'b10:   fix_result = quo;
      default: fix_result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      counter_q <= '0;
      funct3_q  <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      acc_q     <= acc_d;
      counter_q <= counter_d;
      funct3_q  <= funct3_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = fast_path ? DONE : CALC;
      CALC: if (counter_q == CW'(W-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    acc_d     = acc_q;
    counter_d = counter_q;
    funct3_d  = funct3_q;
    neg_d     = neg_q;
    result_d  = result_q;
    if (!flush) begin
      unique case (state_q)
        IDLE: if (start) begin
          if (fast_path) begin
            result_d = fast_result;
          end else begin
            a_mag_d   = a_mag;
            b_mag_d   = b_mag;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend in.
            acc_d     = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
            counter_d = '0;
            funct3_d  = funct3;
            neg_d     = op_neg;
          end
        end
        CALC: begin
          acc_d     = funct3_q[2] ? div_step : mul_step;
          counter_d = counter_q + CW'(1);
        end
        FIX: result_d = fix_result;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall  = ((state_q == IDLE) & start) | (state_q == CALC) | (state_q == FIX);
    done   = (state_q == DONE) & ~flush;
    result = result_q;
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases plus random ops,
// checked against plain 64-bit arithmetic.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          n_reset, start, flush;
  logic [2:0]    funct3;
  logic [W-1:0]  operand_a, operand_b;
  logic          stall, done;
  logic [W-1:0]  result;

  ex_muldiv_unit #(.data_bits(W)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          dcyc;
    logic [2:0]  f3;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int passes = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result_f3_%0d", e.f3), result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.dcyc));
      end
    end
  end

  // Issues one op in the cycle after the next rising edge and waits for its done.
  // With hold=1 start stays high and operands are scrambled while busy.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
    e.res  = ref_result(f3, a, b);
    e.f3   = f3;
    e.dcyc = cyc + (is_fast(f3, a, b) ? 1 : 34);
    sb_q.push_back(e);
    last_res = e.res;
    #1 check("stall_cycle0", {31'b0, stall}, 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk); #1;
      if (hold) begin
        operand_a = $urandom; operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        check("stall_at_done", {31'b0, stall}, 32'd0);
      end else begin
        check("stall_busy", {31'b0, stall}, 32'd1);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    n_reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    operand_a = '0; operand_b = '0;
    #2 n_reset = 1'b0;
    #1;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(1);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(3'd5, 32'd100, 32'd7, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, 1'b1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(2);

    // Flush a DIV at cycle 10, then restart at cycle 12.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; operand_a = $urandom; operand_b = $urandom | 32'd1;
    t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_cycle", 32'(cyc), 32'(t0 + 11));
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_kept", result, last_res);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd1234, 1'b0);

    // Asynchronous reset mid-multiply.
    idle(1);
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; operand_a = $urandom; operand_b = $urandom;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 n_reset = 1'b0;
    #1;
    check("areset_stall", {31'b0, stall}, 32'd0);
    check("areset_done", {31'b0, done}, 32'd0);
    check("areset_result", result, 32'd0);
    last_res = '0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          sel;
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      do_op(f3, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(3);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
